bc_msg_arbiter: RTL and testbench
=================================

// Module: bc_msg_arbiter
// PURPOSE
//  Shares the single cluster-wide broadcast-message bus among PORT_COUNT core PR blocks.
//  - Collects each core's bc_msg_out valid/ready stream.
//  - Picks one message per cycle by round-robin and broadcasts it to every core's bc_msg_in.
//    The broadcast bus has no backpressure.
//  - Drains and counts messages from cores held in core reset, so stale pipe-register
//    contents never reach the bus.
// PARAMETERS
//  PORT_COUNT     16  number of core ports
//  MSG_WIDTH      47  broadcast message width (32 data + 4 strb + addr bits)
//  CORE_ID_WIDTH  4   width of source-port index; equals $clog2(PORT_COUNT)
//  CNT_WIDTH      32  width of statistics counters
// PORTS
//  clk           in   1                     single clock
//  rst           in   1                     synchronous, active-high reset
//  core_reset    in   PORT_COUNT            per-port core reset; high = drain that port
//  bc_stall      in   1                     global pause of new grants
//  s_msg         in   PORT_COUNT*MSG_WIDTH  port i message at [i*MSG_WIDTH +: MSG_WIDTH]
//  s_valid       in   PORT_COUNT            per-port message valid
//  s_ready       out  PORT_COUNT            per-port accept
//  bc_msg        out  MSG_WIDTH             broadcast message
//  bc_msg_valid  out  1                     one-cycle broadcast strobe
//  bc_msg_src    out  CORE_ID_WIDTH         index of the originating port
//  msg_count     out  CNT_WIDTH             broadcast messages issued
//  drop_count    out  CNT_WIDTH             messages drained from ports in reset
// BEHAVIOUR
//  Reset state
//  - While rst is high: s_ready = 0.
//  - First edge after rst goes low, registered outputs are: bc_msg = 0, bc_msg_valid = 0,
//    bc_msg_src = 0, msg_count = 0, drop_count = 0.
//  - Round-robin pointer resets to 0, so port 0 has the highest priority on the first grant.
//  Eligibility
//  - eligible[i] = s_valid[i] & ~core_reset[i].
//  - drain[i]    = s_valid[i] &  core_reset[i].
//  Grant
//  - When bc_stall = 0 and eligible is non-zero, grant exactly one port g.
//  - g is the first eligible port at or above the pointer, searching upward and wrapping
//    modulo PORT_COUNT.
//  - Pointer <= (g+1) mod PORT_COUNT. The pointer is unchanged on cycles with no grant.
//  Handshake
//  - s_ready[i] = ~rst & (grant[i] | drain[i]). It is combinational from s_valid and core_reset.
//    This is legal: the sources are register slices that do not wait for ready.
//  - A transfer occurs when s_valid & s_ready are both high. Any non-granted eligible port
//    holds its message.
//  Drain
//  - Drain ignores bc_stall.
//  - drop_count increments by popcount(drain) each cycle. This runs in parallel with a grant
//    to another port in the same cycle.
//  Latency and throughput
//  - A message granted in cycle t appears on bc_msg / bc_msg_src with bc_msg_valid = 1 in
//    cycle t+1. msg_count increments at the same edge.
//  - Throughput is 1 message per cycle. bc_msg_valid = 0 on cycles after no grant.
//  - bc_msg and bc_msg_src hold their last value when bc_msg_valid = 0.
//  Stall
//  - bc_stall is sampled combinationally and blocks the grant in that same cycle.
//  - A message granted before the stall still broadcasts in the following cycle.
//  Fairness
//  - With all ports continuously eligible, each port is granted once per PORT_COUNT cycles.
//  Other rules
//  - Counters wrap modulo 2^CNT_WIDTH.
//  - Raising core_reset on a port mid-stream drains that port from the same cycle.
//    A message already granted is still broadcast.
//  - rst asserted mid-operation discards the in-flight output at the next edge.
//    Sources are reset by the same rst.
// TESTING
//  1. Reset check -> after rst: no s_ready asserted, all outputs 0.
//     Then a single s_valid[3] with msg 47'h1234 -> s_ready[3] in the same cycle;
//     next cycle bc_msg=47'h1234, bc_msg_src=3, valid=1; msg_count=1.
//  2. All 16 ports valid continuously for 32 cycles -> grants in order 0,1,...,15,0,...,15.
//     Each port is granted twice; msg_count=32; no bubble in bc_msg_valid.
//  3. Ports 2 and 9 valid, pointer at 10 -> port 2 granted first, then 9; pointer ends at 10.
//  4. bc_stall=1 for 5 cycles with ports 1 and 4 valid -> no grants and bc_msg_valid=0.
//     The grant issued the cycle before the stall still broadcasts.
//     After release, port 1 then port 4.
//  5. core_reset[5]=1 with s_valid[5] held for 3 cycles while port 6 is valid ->
//     s_ready[5]=1 each cycle; drop_count=3; port 6 broadcast normally;
//     src 5 never appears on the bus.
//  6. rst pulse while ports are streaming -> bc_msg_valid=0 and counters 0 after the edge;
//     arbitration restarts at port 0.

Source files
------------

// File: rtl/bc_msg_arbiter.sv
// Broadcast-message bus arbiter.
// Collects PORT_COUNT core message streams and grants one port per cycle by round-robin.
// The granted message is broadcast to all cores one cycle later.
// Messages from ports held in core reset are drained and counted without reaching the bus.
module bc_msg_arbiter #(
    parameter int PORT_COUNT    = 16,
    parameter int MSG_WIDTH     = 47,
    parameter int CORE_ID_WIDTH = 4,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PORT_COUNT-1:0]           core_reset,
    input  logic                            bc_stall,
    input  logic [PORT_COUNT*MSG_WIDTH-1:0] s_msg,
    input  logic [PORT_COUNT-1:0]           s_valid,
    output logic [PORT_COUNT-1:0]           s_ready,
    output logic [MSG_WIDTH-1:0]            bc_msg,
    output logic                            bc_msg_valid,
    output logic [CORE_ID_WIDTH-1:0]        bc_msg_src,
    output logic [CNT_WIDTH-1:0]            msg_count,
    output logic [CNT_WIDTH-1:0]            drop_count
);

    logic [PORT_COUNT-1:0]    eligible;
    logic [PORT_COUNT-1:0]    drain;
    logic [PORT_COUNT-1:0]    rot_p0;
    logic [PORT_COUNT-1:0]    grant_p0;
    logic                     gnt_vld_p0;
    logic [CORE_ID_WIDTH:0]   gnt_off_p0;
    logic [CORE_ID_WIDTH:0]   gnt_sum_p0;
    logic [CORE_ID_WIDTH-1:0] gnt_idx_p0;
    logic [MSG_WIDTH-1:0]     gnt_msg_p0;

    logic [CORE_ID_WIDTH-1:0] rr_ptr;
    logic                     vld_p1;
    logic [MSG_WIDTH-1:0]     msg_p1;
    logic [CORE_ID_WIDTH-1:0] src_p1;
    logic [CNT_WIDTH-1:0]     msg_cnt;
    logic [CNT_WIDTH-1:0]     drop_cnt;

    // Number of ports draining this cycle, sized to the counter width.
    function automatic logic [CNT_WIDTH-1:0] popcount(input logic [PORT_COUNT-1:0] v);
        logic [CNT_WIDTH-1:0] sum;
        sum = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            sum = sum + CNT_WIDTH'(v[i]);
        end
        return sum;
    endfunction

    // Round-robin successor of a port index, wrapping at PORT_COUNT (which need not be 2^N).
    function automatic logic [CORE_ID_WIDTH-1:0] next_ptr(input logic [CORE_ID_WIDTH-1:0] g);
        if (g == CORE_ID_WIDTH'(PORT_COUNT - 1)) begin
            return '0;
        end
        return g + CORE_ID_WIDTH'(1);
    endfunction

    assign eligible = s_valid & ~core_reset;
    assign drain    = s_valid &  core_reset;

    // Stage p0: rotate eligibility so the pointer sits at bit 0, take the first set bit,
    // then map the offset back to an absolute port index modulo PORT_COUNT.
    always_comb begin
        rot_p0     = PORT_COUNT'({eligible, eligible} >> rr_ptr);
        gnt_vld_p0 = 1'b0;
        gnt_off_p0 = '0;
        if (!bc_stall) begin
            for (int k = 0; k < PORT_COUNT; k++) begin
                if (!gnt_vld_p0 && rot_p0[k]) begin
                    gnt_vld_p0 = 1'b1;
                    gnt_off_p0 = (CORE_ID_WIDTH+1)'(k);
                end
            end
        end
        gnt_sum_p0 = {1'b0, rr_ptr} + gnt_off_p0;
        if (gnt_sum_p0 >= (CORE_ID_WIDTH+1)'(PORT_COUNT)) begin
            gnt_sum_p0 = gnt_sum_p0 - (CORE_ID_WIDTH+1)'(PORT_COUNT);
        end
        gnt_idx_p0 = gnt_sum_p0[CORE_ID_WIDTH-1:0];
    end

    // Stage p0: one-hot grant vector and the granted port's message.
    always_comb begin
        grant_p0   = '0;
        gnt_msg_p0 = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (gnt_vld_p0 && (gnt_idx_p0 == CORE_ID_WIDTH'(i))) begin
                grant_p0[i] = 1'b1;
                gnt_msg_p0  = s_msg[i*MSG_WIDTH +: MSG_WIDTH];
            end
        end
    end

    // Sources are plain register slices, so ready may depend combinationally on valid.
    assign s_ready = {PORT_COUNT{~rst}} & (grant_p0 | drain);

    // Stage p1: broadcast register, round-robin pointer and statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr   <= '0;
            vld_p1   <= 1'b0;
            msg_p1   <= '0;
            src_p1   <= '0;
            msg_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            vld_p1 <= gnt_vld_p0;
            if (gnt_vld_p0) begin
                rr_ptr  <= next_ptr(gnt_idx_p0);
                msg_p1  <= gnt_msg_p0;
                src_p1  <= gnt_idx_p0;
                msg_cnt <= msg_cnt + CNT_WIDTH'(1);
            end
            drop_cnt <= drop_cnt + popcount(drain);
        end
    end

    assign bc_msg       = msg_p1;
    assign bc_msg_valid = vld_p1;
    assign bc_msg_src   = src_p1;
    assign msg_count    = msg_cnt;
    assign drop_count   = drop_cnt;

endmodule

// File: tb/tb_bc_msg_arbiter.sv
// Testbench for bc_msg_arbiter: directed scenarios plus randomized traffic,
// checked against a behavioural reference model of the arbitration rules.
module tb_bc_msg_arbiter;

    localparam int PC = 16;
    localparam int MW = 47;
    localparam int IW = 4;
    localparam int CW = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [PC-1:0]    core_reset;
    logic             bc_stall;
    logic [PC*MW-1:0] s_msg;
    logic [PC-1:0]    s_valid;
    logic [PC-1:0]    s_ready;
    logic [MW-1:0]    bc_msg;
    logic             bc_msg_valid;
    logic [IW-1:0]    bc_msg_src;
    logic [CW-1:0]    msg_count;
    logic [CW-1:0]    drop_count;

    logic [MW-1:0]    msgs [PC];

    int checks = 0;
    int errors = 0;

    // Reference model state
    int            m_ptr = 0;
    logic          m_vld = 1'b0;
    logic [MW-1:0] m_msg = '0;
    int            m_src = 0;
    logic [CW-1:0] m_mc  = '0;
    logic [CW-1:0] m_dc  = '0;
    logic          m_gv;
    int            m_g;
    logic [PC-1:0] m_ready;

    bc_msg_arbiter #(.PORT_COUNT(PC), .MSG_WIDTH(MW), .CORE_ID_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .core_reset(core_reset), .bc_stall(bc_stall),
        .s_msg(s_msg), .s_valid(s_valid), .s_ready(s_ready),
        .bc_msg(bc_msg), .bc_msg_valid(bc_msg_valid), .bc_msg_src(bc_msg_src),
        .msg_count(msg_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        s_msg = '0;
        for (int i = 0; i < PC; i++) s_msg[i*MW +: MW] = msgs[i];
    end

    function automatic logic [MW-1:0] rand_msg();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[MW-1:0];
    endfunction

    task automatic randomize_msgs();
        for (int i = 0; i < PC; i++) msgs[i] = rand_msg();
    endtask

    // Model: scan upward from the pointer (mod PC) for the first valid port not in reset.
    task automatic model_eval();
        m_gv = 1'b0;
        m_g  = 0;
        m_ready = '0;
        if (!rst) begin
            if (!bc_stall) begin
                for (int k = 0; k < PC; k++) begin
                    int p;
                    p = (m_ptr + k) % PC;
                    if (!m_gv && s_valid[p] && !core_reset[p]) begin
                        m_gv = 1'b1;
                        m_g  = p;
                    end
                end
            end
            m_ready = s_valid & core_reset;
            if (m_gv) m_ready[m_g] = 1'b1;
        end
    endtask

    task automatic model_commit();
        if (rst) begin
            m_ptr = 0; m_vld = 1'b0; m_msg = '0; m_src = 0; m_mc = '0; m_dc = '0;
        end else begin
            m_vld = m_gv;
            if (m_gv) begin
                m_msg = msgs[m_g];
                m_src = m_g;
                m_ptr = (m_g + 1) % PC;
                m_mc  = m_mc + 32'd1;
            end
            m_dc = m_dc + 32'($countones(s_valid & core_reset));
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_commit();
    endtask

    task automatic do_reset();
        rst = 1'b1; s_valid = '0; core_reset = '0; bc_stall = 1'b0;
        settle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [PC-1:0] one;
        rst = 1'b1; s_valid = PC'($urandom); core_reset = PC'($urandom); bc_stall = 1'b0;
        randomize_msgs();
        settle();
        checks++;
        if (s_ready !== '0) begin
            errors++; $display("FAIL reset_ready got=%h exp=0000", s_ready);
        end
        tick();
        rst = 1'b0; s_valid = '0; core_reset = '0;
        settle();
        tick();
        checks++;
        if ({bc_msg_valid, bc_msg_src, bc_msg, msg_count, drop_count} !== '0) begin
            errors++;
            $display("FAIL reset_out got vld=%0b src=%0d msg=%h mc=%0d dc=%0d exp all 0",
                     bc_msg_valid, bc_msg_src, bc_msg, msg_count, drop_count);
        end
        msgs[3] = 47'h1234; s_valid = 16'h0008;
        settle();
        one = 16'h0008;
        checks++;
        if (s_ready !== one) begin
            errors++; $display("FAIL single_ready got=%h exp=%h", s_ready, one);
        end
        tick();
        checks++;
        if (bc_msg !== 47'h1234 || bc_msg_src !== 4'd3 || bc_msg_valid !== 1'b1 || msg_count !== 32'd1) begin
            errors++;
            $display("FAIL single_bcast got msg=%h src=%0d vld=%0b mc=%0d exp msg=1234 src=3 vld=1 mc=1",
                     bc_msg, bc_msg_src, bc_msg_valid, msg_count);
        end
        s_valid = '0;
        settle();
        tick();
        checks++;
        if (bc_msg_valid !== 1'b0 || bc_msg !== 47'h1234 || bc_msg_src !== 4'd3) begin
            errors++;
            $display("FAIL idle_hold got vld=%0b msg=%h src=%0d exp vld=0 msg=1234 src=3",
                     bc_msg_valid, bc_msg, bc_msg_src);
        end
    endtask

    task automatic test_round_robin();
        logic [PC-1:0] one;
        do_reset();
        for (int i = 0; i < 32; i++) begin
            s_valid = '1;
            randomize_msgs();
            settle();
            one = 16'h0001;
            one = one << (i % PC);
            checks++;
            if (s_ready !== one) begin
                errors++; $display("FAIL rr_ready cyc=%0d got=%h exp=%h", i, s_ready, one);
            end
            tick();
            checks++;
            if (bc_msg_valid !== 1'b1 || bc_msg_src !== IW'(i % PC) || bc_msg !== msgs[i % PC]) begin
                errors++;
                $display("FAIL rr_bcast cyc=%0d got vld=%0b src=%0d msg=%h exp vld=1 src=%0d msg=%h",
                         i, bc_msg_valid, bc_msg_src, bc_msg, i % PC, msgs[i % PC]);
            end
        end
        checks++;
        if (msg_count !== 32'd32) begin
            errors++; $display("FAIL rr_count got=%0d exp=32", msg_count);
        end
        s_valid = '0;
    endtask

    task automatic test_wrap();
        do_reset();
        s_valid = 16'h0200;
        settle();
        tick();
        s_valid = 16'h0204;
        settle();
        checks++;
        if (s_ready !== 16'h0004) begin
            errors++; $display("FAIL wrap_ready got=%h exp=0004", s_ready);
        end
        tick();
        checks++;
        if (bc_msg_src !== 4'd2 || bc_msg_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_first got src=%0d vld=%0b exp src=2 vld=1", bc_msg_src, bc_msg_valid);
        end
        s_valid = 16'h0200;
        settle();
        tick();
        checks++;
        if (bc_msg_src !== 4'd9 || bc_msg_valid !== 1'b1) begin
            errors++; $display("FAIL wrap_second got src=%0d vld=%0b exp src=9 vld=1", bc_msg_src, bc_msg_valid);
        end
        s_valid = 16'h0600;
        settle();
        checks++;
        if (s_ready !== 16'h0400) begin
            errors++; $display("FAIL wrap_ptr10 got=%h exp=0400", s_ready);
        end
        tick();
        s_valid = '0;
    endtask

    task automatic test_stall();
        do_reset();
        s_valid = 16'h0080;
        settle();
        tick();
        s_valid = 16'h0012; bc_stall = 1'b1;
        for (int j = 0; j < 5; j++) begin
            settle();
            if (j == 0) begin
                checks++;
                if (bc_msg_valid !== 1'b1 || bc_msg_src !== 4'd7) begin
                    errors++;
                    $display("FAIL stall_inflight got vld=%0b src=%0d exp vld=1 src=7", bc_msg_valid, bc_msg_src);
                end
            end
            checks++;
            if (s_ready !== '0) begin
                errors++; $display("FAIL stall_ready cyc=%0d got=%h exp=0000", j, s_ready);
            end
            tick();
            checks++;
            if (bc_msg_valid !== 1'b0) begin
                errors++; $display("FAIL stall_vld cyc=%0d got=%0b exp=0", j, bc_msg_valid);
            end
        end
        bc_stall = 1'b0;
        settle();
        tick();
        checks++;
        if (bc_msg_src !== 4'd1 || bc_msg_valid !== 1'b1) begin
            errors++; $display("FAIL stall_rel1 got src=%0d vld=%0b exp src=1 vld=1", bc_msg_src, bc_msg_valid);
        end
        s_valid = 16'h0010;
        settle();
        tick();
        checks++;
        if (bc_msg_src !== 4'd4 || bc_msg_valid !== 1'b1) begin
            errors++; $display("FAIL stall_rel2 got src=%0d vld=%0b exp src=4 vld=1", bc_msg_src, bc_msg_valid);
        end
        s_valid = '0;
    endtask

    task automatic test_drain();
        do_reset();
        core_reset = 16'h0020;
        for (int j = 0; j < 3; j++) begin
            s_valid = 16'h0060;
            randomize_msgs();
            settle();
            checks++;
            if (s_ready !== 16'h0060) begin
                errors++; $display("FAIL drain_ready cyc=%0d got=%h exp=0060", j, s_ready);
            end
            tick();
            checks++;
            if (bc_msg_src !== 4'd6 || bc_msg_valid !== 1'b1 || bc_msg !== msgs[6]) begin
                errors++;
                $display("FAIL drain_bcast cyc=%0d got src=%0d vld=%0b msg=%h exp src=6 vld=1 msg=%h",
                         j, bc_msg_src, bc_msg_valid, bc_msg, msgs[6]);
            end
        end
        checks++;
        if (drop_count !== 32'd3 || msg_count !== 32'd3) begin
            errors++; $display("FAIL drain_count got dc=%0d mc=%0d exp dc=3 mc=3", drop_count, msg_count);
        end
        core_reset = '0; s_valid = '0;
    endtask

    task automatic test_rst_mid();
        for (int j = 0; j < 3; j++) begin
            s_valid = '1;
            randomize_msgs();
            settle();
            tick();
        end
        rst = 1'b1;
        settle();
        checks++;
        if (s_ready !== '0) begin
            errors++; $display("FAIL rstmid_ready got=%h exp=0000", s_ready);
        end
        tick();
        checks++;
        if ({bc_msg_valid, bc_msg_src, bc_msg, msg_count, drop_count} !== '0) begin
            errors++;
            $display("FAIL rstmid_out got vld=%0b src=%0d msg=%h mc=%0d dc=%0d exp all 0",
                     bc_msg_valid, bc_msg_src, bc_msg, msg_count, drop_count);
        end
        rst = 1'b0;
        settle();
        checks++;
        if (s_ready !== 16'h0001) begin
            errors++; $display("FAIL rstmid_restart got=%h exp=0001", s_ready);
        end
        tick();
        checks++;
        if (bc_msg_src !== 4'd0 || bc_msg_valid !== 1'b1 || msg_count !== 32'd1) begin
            errors++;
            $display("FAIL rstmid_first got src=%0d vld=%0b mc=%0d exp src=0 vld=1 mc=1",
                     bc_msg_src, bc_msg_valid, msg_count);
        end
        s_valid = '0;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst        = ($urandom_range(0, 59) == 0);
            s_valid    = PC'($urandom);
            core_reset = PC'($urandom & $urandom & $urandom);
            bc_stall   = ($urandom_range(0, 4) == 0);
            randomize_msgs();
            settle();
            checks++;
            if (s_ready !== m_ready) begin
                errors++; $display("FAIL rand_ready cyc=%0d got=%h exp=%h", i, s_ready, m_ready);
            end
            tick();
            checks++;
            if ({bc_msg_valid, bc_msg_src, bc_msg, msg_count, drop_count} !==
                {m_vld, IW'(m_src), m_msg, m_mc, m_dc}) begin
                errors++;
                $display("FAIL rand_out cyc=%0d got vld=%0b src=%0d msg=%h mc=%0d dc=%0d exp vld=%0b src=%0d msg=%h mc=%0d dc=%0d",
                         i, bc_msg_valid, bc_msg_src, bc_msg, msg_count, drop_count,
                         m_vld, m_src, m_msg, m_mc, m_dc);
            end
        end
        rst = 1'b0; s_valid = '0; core_reset = '0; bc_stall = 1'b0;
    endtask

    initial begin
        rst = 1'b1; bc_stall = 1'b0; core_reset = '0; s_valid = '0;
        for (int i = 0; i < PC; i++) msgs[i] = '0;
        test_reset();
        test_round_robin();
        test_wrap();
        test_stall();
        test_drain();
        test_rst_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
